// File: rtl/ascii_keyenc.sv
// ASCII to USB HID key event encoder (Spanish layout): each accepted byte yields
// a press report held HOLD_CYCLES, then a release report held GAP_CYCLES.
module ascii_keyenc #(
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 16
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_valid,
    input  logic [7:0] i_byte,
    output logic       o_ready,
    output logic [7:0] o_key,
    output logic [7:0] o_mod,
    output logic       o_stb,
    output logic       o_err
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESS   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    key_q, key_d;
    logic [7:0]    mod_q, mod_d;
    logic          stb_q, stb_d;
    logic          err_q, err_d;

    logic          lk_hit;
    logic [7:0]    lk_mod;
    logic [7:0]    lk_key;

    // Returns {hit, modifier, scan code}; explicit cases take priority over the ranges.
    function automatic logic [16:0] lookup(input logic [7:0] c);
        logic       hit;
        logic [7:0] md;
        logic [7:0] ky;
        hit = 1'b1;
        md  = 8'h00;
        ky  = 8'h00;
        case (c)
            8'h0D: ky = 8'h28;
            8'h0A: ky = 8'h58;
            8'h1B: ky = 8'h29;
            8'h08: ky = 8'h2A;
            8'h7F: ky = 8'h4C;
            8'h09: ky = 8'h2B;
            8'h20: ky = 8'h2C;
            8'h27: ky = 8'h2D;
            8'h60: ky = 8'h2F;
            8'h2B: ky = 8'h30;
            8'h2C: ky = 8'h36;
            8'h2E: ky = 8'h37;
            8'h2D: ky = 8'h38;
            8'h3C: ky = 8'h64;
            8'h21: begin md = 8'h02; ky = 8'h1E; end
            8'h22: begin md = 8'h02; ky = 8'h1F; end
            8'h24: begin md = 8'h02; ky = 8'h21; end
            8'h25: begin md = 8'h02; ky = 8'h22; end
            8'h26: begin md = 8'h02; ky = 8'h23; end
            8'h2F: begin md = 8'h02; ky = 8'h24; end
            8'h28: begin md = 8'h02; ky = 8'h25; end
            8'h29: begin md = 8'h02; ky = 8'h26; end
            8'h3D: begin md = 8'h02; ky = 8'h27; end
            8'h3F: begin md = 8'h02; ky = 8'h2D; end
            8'h5E: begin md = 8'h02; ky = 8'h2F; end
            8'h2A: begin md = 8'h02; ky = 8'h30; end
            8'h3B: begin md = 8'h02; ky = 8'h36; end
            8'h3A: begin md = 8'h02; ky = 8'h37; end
            8'h5F: begin md = 8'h02; ky = 8'h38; end
            8'h3E: begin md = 8'h02; ky = 8'h64; end
            8'h7C: begin md = 8'h40; ky = 8'h1E; end
            8'h40: begin md = 8'h40; ky = 8'h1F; end
            8'h23: begin md = 8'h40; ky = 8'h20; end
            8'h7E: begin md = 8'h40; ky = 8'h21; end
            8'h5B: begin md = 8'h40; ky = 8'h2F; end
            8'h5D: begin md = 8'h40; ky = 8'h30; end
            8'h7D: begin md = 8'h40; ky = 8'h32; end
            8'h7B: begin md = 8'h40; ky = 8'h34; end
            8'h5C: begin md = 8'h40; ky = 8'h35; end
            default: begin
                if (c >= 8'h01 && c <= 8'h1A) begin
                    md = 8'h01;
                    ky = c + 8'h03;
                end else if (c >= 8'h61 && c <= 8'h7A) begin
                    ky = c - 8'h5D;
                end else if (c >= 8'h41 && c <= 8'h5A) begin
                    md = 8'h02;
                    ky = c - 8'h3D;
                end else if (c >= 8'h31 && c <= 8'h39) begin
                    ky = c - 8'h13;
                end else if (c == 8'h30) begin
                    ky = 8'h27;
                end else begin
                    hit = 1'b0;
                end
            end
        endcase
        return {hit, md, ky};
    endfunction

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            key_q   <= 8'h00;
            mod_q   <= 8'h00;
            stb_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            mod_q   <= mod_d;
            stb_q   <= stb_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        {lk_hit, lk_mod, lk_key} = lookup(i_byte);
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        mod_d   = mod_q;
        stb_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    if (lk_hit) begin
                        state_d = S_PRESS;
                        cnt_d   = CW'(HOLD_CYCLES - 1);
                        key_d   = lk_key;
                        mod_d   = lk_mod;
                        stb_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_PRESS: begin
                if (cnt_q == '0) begin
                    state_d = S_RELEASE;
                    cnt_d   = CW'(GAP_CYCLES - 1);
                    key_d   = 8'h00;
                    mod_d   = 8'h00;
                    stb_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RELEASE: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        o_ready = (state_q == S_IDLE);
        o_key   = key_q;
        o_mod   = mod_q;
        o_stb   = stb_q;
        o_err   = err_q;
    end

endmodule

// File: tb/tb_ascii_keyenc.sv
// Bench for ascii_keyenc: table-driven reference model checked every cycle,
// directed literal checks, and a full byte sweep through a scan-code decoder.
module tb_ascii_keyenc;

    localparam int HOLD = 4;
    localparam int GAP  = 3;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] byte_i = 8'h00;
    logic       o_ready, o_stb, o_err;
    logic [7:0] o_key, o_mod;

    ascii_keyenc #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_valid(valid), .i_byte(byte_i),
        .o_ready(o_ready), .o_key(o_key), .o_mod(o_mod), .o_stb(o_stb), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int stb_cnt = 0;

    // Encoding table built from the layout lists
    logic       m_ok [256];
    logic [7:0] m_key[256];
    logic [7:0] m_mod[256];

    string      un_s = " '`+,.-<";
    logic [7:0] un_k[8]  = '{8'h2C, 8'h2D, 8'h2F, 8'h30, 8'h36, 8'h37, 8'h38, 8'h64};
    logic [7:0] sh_c[16] = '{8'h21, 8'h22, 8'h24, 8'h25, 8'h26, 8'h2F, 8'h28, 8'h29,
                             8'h3D, 8'h3F, 8'h5E, 8'h2A, 8'h3B, 8'h3A, 8'h5F, 8'h3E};
    logic [7:0] sh_k[16] = '{8'h1E, 8'h1F, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                             8'h27, 8'h2D, 8'h2F, 8'h30, 8'h36, 8'h37, 8'h38, 8'h64};
    logic [7:0] ag_c[9]  = '{8'h7C, 8'h40, 8'h23, 8'h7E, 8'h5B, 8'h5D, 8'h7D, 8'h7B, 8'h5C};
    logic [7:0] ag_k[9]  = '{8'h1E, 8'h1F, 8'h20, 8'h21, 8'h2F, 8'h30, 8'h32, 8'h34, 8'h35};
    logic [7:0] sp_c[6]  = '{8'h0D, 8'h0A, 8'h1B, 8'h08, 8'h7F, 8'h09};
    logic [7:0] sp_k[6]  = '{8'h28, 8'h58, 8'h29, 8'h2A, 8'h4C, 8'h2B};

    task automatic set_map(input int c, input logic [7:0] md, input logic [7:0] ky);
        m_ok[c]  = 1'b1;
        m_mod[c] = md;
        m_key[c] = ky;
    endtask

    task automatic build_tables();
        for (int i = 0; i < 256; i++) begin
            m_ok[i] = 1'b0; m_key[i] = 8'h00; m_mod[i] = 8'h00;
        end
        for (int c = 1; c <= 26; c++) set_map(c, 8'h01, 8'(c + 3));
        for (int i = 0; i < 6; i++) set_map(int'(sp_c[i]), 8'h00, sp_k[i]);
        for (int i = 0; i < 26; i++) begin
            set_map(8'h61 + i, 8'h00, 8'(4 + i));
            set_map(8'h41 + i, 8'h02, 8'(4 + i));
        end
        for (int i = 1; i <= 9; i++) set_map(8'h30 + i, 8'h00, 8'(8'h1D + i));
        set_map(8'h30, 8'h00, 8'h27);
        for (int i = 0; i < 8; i++)  set_map(int'(un_s[i]), 8'h00, un_k[i]);
        for (int i = 0; i < 16; i++) set_map(int'(sh_c[i]), 8'h02, sh_k[i]);
        for (int i = 0; i < 9; i++)  set_map(int'(ag_c[i]), 8'h40, ag_k[i]);
    endtask

    // Scan-code-to-character map (the reverse direction, written independently)
    function automatic logic [7:0] dec(input logic [7:0] k, input logic [7:0] m);
        logic [7:0] r;
        r = 8'h00;
        case (m)
            8'h00: begin
                if (k >= 8'h04 && k <= 8'h1D) r = 8'h61 + (k - 8'h04);
                else if (k >= 8'h1E && k <= 8'h26) r = 8'h31 + (k - 8'h1E);
                else case (k)
                    8'h27: r = 8'h30; 8'h28: r = 8'h0D; 8'h58: r = 8'h0A; 8'h29: r = 8'h1B;
                    8'h2A: r = 8'h08; 8'h4C: r = 8'h7F; 8'h2B: r = 8'h09; 8'h2C: r = 8'h20;
                    8'h2D: r = 8'h27; 8'h2F: r = 8'h60; 8'h30: r = 8'h2B; 8'h36: r = 8'h2C;
                    8'h37: r = 8'h2E; 8'h38: r = 8'h2D; 8'h64: r = 8'h3C;
                    default: r = 8'h00;
                endcase
            end
            8'h01: if (k >= 8'h04 && k <= 8'h1D) r = k - 8'h03;
            8'h02: begin
                if (k >= 8'h04 && k <= 8'h1D) r = 8'h41 + (k - 8'h04);
                else case (k)
                    8'h1E: r = 8'h21; 8'h1F: r = 8'h22; 8'h21: r = 8'h24; 8'h22: r = 8'h25;
                    8'h23: r = 8'h26; 8'h24: r = 8'h2F; 8'h25: r = 8'h28; 8'h26: r = 8'h29;
                    8'h27: r = 8'h3D; 8'h2D: r = 8'h3F; 8'h2F: r = 8'h5E; 8'h30: r = 8'h2A;
                    8'h36: r = 8'h3B; 8'h37: r = 8'h3A; 8'h38: r = 8'h5F; 8'h64: r = 8'h3E;
                    default: r = 8'h00;
                endcase
            end
            8'h40: case (k)
                8'h1E: r = 8'h7C; 8'h1F: r = 8'h40; 8'h20: r = 8'h23; 8'h21: r = 8'h7E;
                8'h2F: r = 8'h5B; 8'h30: r = 8'h5D; 8'h32: r = 8'h7D; 8'h34: r = 8'h7B;
                8'h35: r = 8'h5C;
                default: r = 8'h00;
            endcase
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Timeline model: absolute edge numbers for release and ready
    int         e_num = 0;
    int         rel_e = -1;
    int         rdy_e = 0;
    logic       m_rdy = 1'b0;
    logic       m_inrst = 1'b1;
    logic       m_stb = 1'b0;
    logic       m_err = 1'b0;
    logic [7:0] mk = 8'h00;
    logic [7:0] mm = 8'h00;

    always @(posedge clk) begin
        e_num = e_num + 1;
        if (!rstn) begin
            m_inrst = 1'b1;
            rel_e = -1; rdy_e = e_num; m_rdy = 1'b1;
            mk = 8'h00; mm = 8'h00; m_stb = 1'b0; m_err = 1'b0;
        end else begin
            m_inrst = 1'b0;
            m_stb = 1'b0; m_err = 1'b0;
            if (m_rdy && valid) begin
                if (m_ok[byte_i]) begin
                    mk = m_key[byte_i]; mm = m_mod[byte_i]; m_stb = 1'b1;
                    rel_e = e_num + HOLD;
                    rdy_e = e_num + HOLD + GAP;
                end else begin
                    m_err = 1'b1;
                end
            end else if (e_num == rel_e) begin
                mk = 8'h00; mm = 8'h00; m_stb = 1'b1;
            end
            m_rdy = (e_num >= rdy_e);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance one cycle and compare every output against the model
    task automatic tick();
        @(posedge clk);
        #1;
        chk("cyc o_key", o_key, mk);
        chk("cyc o_mod", o_mod, mm);
        chk("cyc o_stb", o_stb, m_stb);
        chk("cyc o_err", o_err, m_err);
        if (!m_inrst) chk("cyc o_ready", o_ready, m_rdy);
        if (o_stb === 1'b1) stb_cnt++;
    endtask

    task automatic send(input logic [7:0] b);
        valid = 1'b1;
        byte_i = b;
        tick();
        valid = 1'b0;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (o_ready !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        chk("wait o_ready", o_ready, 1'b1);
    endtask

    logic [7:0] dir_c[4] = '{8'h51, 8'h40, 8'h03, 8'h0D};
    logic [7:0] dir_k[4] = '{8'h14, 8'h1F, 8'h06, 8'h28};
    logic [7:0] dir_m[4] = '{8'h02, 8'h40, 8'h01, 8'h00};

    initial begin
        build_tables();
        chk("model 'a' key", m_key[8'h61], 8'h04);
        chk("model '>' key", m_key[8'h3E], 8'h64);
        chk("model ctrl-Z mod", m_mod[8'h1A], 8'h01);
        chk("model 0x1C ok", m_ok[8'h1C], 1'b0);

        rstn = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        chk("rst o_ready", o_ready, 1'b1);
        chk("rst o_key", o_key, 8'h00);
        chk("rst o_stb", o_stb, 1'b0);

        // 'a' timing
        send(8'h61);
        chk("a T+1 key", o_key, 8'h04);
        chk("a T+1 mod", o_mod, 8'h00);
        chk("a T+1 stb", o_stb, 1'b1);
        repeat (3) tick();
        chk("a T+4 key", o_key, 8'h04);
        chk("a T+4 stb", o_stb, 1'b0);
        tick();
        chk("a T+5 key", o_key, 8'h00);
        chk("a T+5 stb", o_stb, 1'b1);
        chk("a T+5 ready", o_ready, 1'b0);
        repeat (2) tick();
        chk("a T+7 ready", o_ready, 1'b0);
        tick();
        chk("a T+8 ready", o_ready, 1'b1);

        for (int i = 0; i < 4; i++) begin
            wait_ready();
            stb_cnt = 0;
            send(dir_c[i]);
            chk("dir key", o_key, dir_k[i]);
            chk("dir mod", o_mod, dir_m[i]);
            wait_ready();
            chk("dir stb count", stb_cnt, 2);
        end

        // Unmapped bytes, then immediate accept
        wait_ready();
        send(8'hE7);
        chk("E7 err", o_err, 1'b1);
        chk("E7 stb", o_stb, 1'b0);
        chk("E7 ready", o_ready, 1'b1);
        send(8'h00);
        chk("00 err", o_err, 1'b1);
        chk("00 ready", o_ready, 1'b1);
        send(8'h62);
        chk("after err stb", o_stb, 1'b1);
        chk("after err key", o_key, 8'h05);

        // Busy: valid held with changing bytes
        wait_ready();
        stb_cnt = 0;
        send(8'h78);
        chk("busy key", o_key, 8'h1B);
        for (int i = 0; i < 7; i++) begin
            valid = 1'b1;
            byte_i = 8'h31 + 8'(i);
            chk("busy ready", o_ready, 1'b0);
            tick();
        end
        valid = 1'b0;
        chk("busy stb count", stb_cnt, 2);
        chk("busy back ready", o_ready, 1'b1);

        // Reset during PRESS
        tick();
        stb_cnt = 0;
        send(8'h62);
        tick();
        rstn = 1'b0;
        tick();
        chk("midrst key", o_key, 8'h00);
        chk("midrst mod", o_mod, 8'h00);
        chk("midrst stb", o_stb, 1'b0);
        rstn = 1'b1;
        tick();
        chk("midrst ready", o_ready, 1'b1);
        repeat (8) tick();
        chk("midrst stb count", stb_cnt, 1);

        // Full sweep with round trip
        for (int b = 0; b < 256; b++) begin
            wait_ready();
            send(8'(b));
            if (m_ok[b]) begin
                chk("sweep stb", o_stb, 1'b1);
                chk("sweep roundtrip", dec(o_key, o_mod), 8'(b));
            end else begin
                chk("sweep err", o_err, 1'b1);
            end
        end
        wait_ready();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

endmodule
